// File: rtl/misr_pkg.sv
// rtl/misr_pkg.sv - shared types, defaults and MISR step function for the response compactor
// Purpose : FSM state encoding, default polynomial/seed, and the reference
//           MISR next-state function used by misr_reg.
// Contents: state_t {IDLE,RUN,DONE}; POLY_DEFAULT; SEED_DEFAULT; MISR_MAX_W;
//           misr_next(sig,data,poly,w) -> next signature (low w bits valid).
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // x^16 + x^5 + x^3 + x^2 + 1, x^16 implied
  localparam logic [15:0] POLY_DEFAULT = 16'h002D;
  localparam logic [15:0] SEED_DEFAULT = 16'hFFFF;

  // Widest signature the shared function handles; callers zero-extend into it.
  localparam int MISR_MAX_W = 64;

  // One MISR step for a w-bit register: shift left, fold the outgoing MSB
  // back through the taps, then XOR the response in.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           w
  );
    logic [MISR_MAX_W-1:0] keep;
    logic [MISR_MAX_W-1:0] nxt;
    logic [5:0]            msb_idx;
    msb_idx = 6'(w - 1);
    if (w >= MISR_MAX_W) keep = {MISR_MAX_W{1'b1}};
    else                 keep = (MISR_MAX_W'(1) << w) - MISR_MAX_W'(1);
    nxt = (sig << 1) ^ (sig[msb_idx] ? poly : '0) ^ data;
    return nxt & keep;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// rtl/misr_reg.sv - SIG_W-bit MISR register with load/enable
// Purpose : holds the signature; loads SEED on rst or load, steps on en.
// Ports   : clk, rst (sync, active-high), load (reseed), en (compact data),
//           data[WIDTH-1:0] (response), sig (current contents),
//           sig_next (value sig takes if en is taken this cycle).
module misr_reg
  import misr_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               WIDTH = 1,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  logic [MISR_MAX_W-1:0] nxt_full;

  always_comb begin
    nxt_full = misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(data),
                         MISR_MAX_W'(POLY), SIG_W);
  end

  assign sig_next = nxt_full[SIG_W-1:0];

  // Upper bits of the shared-width result are always zero here.
  generate
    if (SIG_W < MISR_MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^nxt_full[MISR_MAX_W-1:SIG_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || load) sig <= SEED;
    else if (en)     sig <= sig_next;
  end

endmodule

// File: rtl/resp_misr_compactor.sv
// rtl/resp_misr_compactor.sv - compacts NUM_PAT CUT responses into a MISR signature and checks it
// Purpose : per session (start pulse) accept NUM_PAT responses, compact them in
//           misr_reg, then compare against expected_sig and report pass/done.
// Ports   : clk; rst (sync, active-high); start; resp_valid; resp_data[WIDTH-1:0];
//           resp_mask[WIDTH-1:0] (only with MISR_MASK_EN, 1 = force bit to 0);
//           resp_ready; expected_sig[SIG_W-1:0]; signature[SIG_W-1:0];
//           pat_count[$clog2(NUM_PAT+1)-1:0]; busy; done; pass.
// Config  : define MISR_MASK_EN to add the resp_mask input.
module resp_misr_compactor
  import misr_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(POLY_DEFAULT),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(SEED_DEFAULT),
  parameter int               NUM_PAT = 16,
  localparam int              CW      = $clog2(NUM_PAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
`ifdef MISR_MASK_EN
  input  logic [WIDTH-1:0] resp_mask,
`endif
  output logic             resp_ready,
  input  logic [SIG_W-1:0] expected_sig,
  output logic [SIG_W-1:0] signature,
  output logic [CW-1:0]    pat_count,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  state_t           state;
  logic             accept;
  logic             last;
  logic             load;
  logic [WIDTH-1:0] data_eff;
  logic [SIG_W-1:0] sig_next;

  assign resp_ready = (state == RUN);
  assign accept     = resp_valid & resp_ready;
  assign last       = (pat_count == CW'(NUM_PAT - 1));
  // start only reseeds outside RUN; a start during RUN is ignored.
  assign load       = start & (state != RUN);

`ifdef MISR_MASK_EN
  assign data_eff = resp_data & ~resp_mask;
`else
  assign data_eff = resp_data;
`endif

  misr_reg #(
    .SIG_W (SIG_W),
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (accept),
    .data     (data_eff),
    .sig      (signature),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            pat_count <= pat_count + CW'(1);
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Compare the value the register is taking on this same edge.
              pass  <= (sig_next == expected_sig);
            end
          end
        end
        default: begin
          if (start) begin
            state     <= RUN;
            pat_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
